// File: rtl/disp_sched_pkg.sv
// Shared types and constants for the display page scheduler.
package disp_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAdvance,
    StLoad,
    StShow
  } state_e;

  localparam int unsigned NUM_PAGES = 4;
  localparam logic [3:0]  BLANK_ALL = 4'b1111;
  localparam int unsigned TICK_W    = 4;

  // Leading-zero suppression mask for four BCD digits; digit 0 always stays lit.
  function automatic logic [3:0] lz_blank(input logic [15:0] digits);
    logic [3:0] mask;
    mask = '0;
    if (digits[15:12] == 4'd0) begin
      mask[3] = 1'b1;
      if (digits[11:8] == 4'd0) begin
        mask[2] = 1'b1;
        if (digits[7:4] == 4'd0) begin
          mask[1] = 1'b1;
        end
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/next_valid_page.sv
// Round-robin search for the next enabled page after the current one, wrapping 3 -> 0.
module next_valid_page
  import disp_sched_pkg::*;
(
  input  logic [1:0]           cur_idx,
  input  logic [NUM_PAGES-1:0] mask,
  output logic [1:0]           next_idx,
  output logic                 any_valid
);

  logic [1:0] cand;

  // Walk candidates farthest-first so the nearest enabled page wins; falls back to cur_idx.
  always_comb begin
    next_idx = cur_idx;
    cand     = cur_idx;
    for (int k = NUM_PAGES - 1; k >= 1; k--) begin
      cand = cur_idx + 2'(k);
      if (mask[cand]) begin
        next_idx = cand;
      end
    end
  end

  assign any_valid = |mask;

endmodule

// File: rtl/display_scheduler.sv
// Cycles enabled pages of BCD digits onto a 4-digit display with leading-zero suppression.
// Optional saturation blink is compiled in with DISPLAY_SCHED_BLINK_EN.
module display_scheduler
  import disp_sched_pkg::*;
#(
  parameter int unsigned DWELL_TICKS = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        TICK,
  input  logic        START,
  input  logic        NEXT,
  input  logic        SAT,
  input  logic [3:0]  PAGE_VALID,
  input  logic [15:0] PAGE0,
  input  logic [15:0] PAGE1,
  input  logic [15:0] PAGE2,
  input  logic [15:0] PAGE3,
  output logic [3:0]  DIGIT0,
  output logic [3:0]  DIGIT1,
  output logic [3:0]  DIGIT2,
  output logic [3:0]  DIGIT3,
  output logic [3:0]  BLANK,
  output logic [3:0]  DP,
  output logic [1:0]  PAGE_IDX
);

  localparam logic [TICK_W-1:0] TickLast = TICK_W'(DWELL_TICKS - 1);

  state_e            state_q;
  logic [1:0]        page_idx_q;
  logic [TICK_W-1:0] tick_cnt_q;
  logic [15:0]       digits_q;
  logic [3:0]        blank_q;
  logic [3:0]        dp_q;

  logic [1:0]        nvp_cur;
  logic [1:0]        nvp_next;
  logic              nvp_any;
  logic [15:0]       page_sel;
  logic [3:0]        load_blank;
  logic [3:0]        load_dp;
  logic              tick_last;

`ifdef DISPLAY_SCHED_BLINK_EN
  logic              blink_q;
  logic [3:0]        blank_pat_q;
  logic [3:0]        dp_pat_q;
`else
  logic              unused_sat;
  assign unused_sat = SAT;
`endif

  // From IDLE, searching after the last page yields the lowest enabled page.
  assign nvp_cur = (state_q == StIdle) ? 2'(NUM_PAGES - 1) : page_idx_q;

  next_valid_page u_next_valid_page (
    .cur_idx   (nvp_cur),
    .mask      (PAGE_VALID),
    .next_idx  (nvp_next),
    .any_valid (nvp_any)
  );

  always_comb begin
    page_sel = PAGE0;
    case (page_idx_q)
      2'd1:    page_sel = PAGE1;
      2'd2:    page_sel = PAGE2;
      2'd3:    page_sel = PAGE3;
      default: page_sel = PAGE0;
    endcase
  end

  assign load_blank = lz_blank(page_sel);
  assign load_dp    = 4'b0001 << page_idx_q;
  assign tick_last  = (tick_cnt_q == TickLast);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= StIdle;
      page_idx_q  <= '0;
      tick_cnt_q  <= '0;
      digits_q    <= '0;
      blank_q     <= BLANK_ALL;
      dp_q        <= '0;
`ifdef DISPLAY_SCHED_BLINK_EN
      blink_q     <= 1'b0;
      blank_pat_q <= BLANK_ALL;
      dp_pat_q    <= '0;
`endif
    end else if (!START) begin
      state_q <= StIdle;
      blank_q <= BLANK_ALL;
      dp_q    <= '0;
`ifdef DISPLAY_SCHED_BLINK_EN
      blink_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          blank_q <= BLANK_ALL;
          dp_q    <= '0;
`ifdef DISPLAY_SCHED_BLINK_EN
          blink_q <= 1'b0;
`endif
          if (nvp_any) begin
            page_idx_q <= nvp_next;
            state_q    <= StLoad;
          end
        end
        StAdvance: begin
`ifdef DISPLAY_SCHED_BLINK_EN
          if (!SAT) begin
            blink_q <= 1'b0;
            blank_q <= blank_pat_q;
            dp_q    <= dp_pat_q;
          end
`endif
          if (nvp_any) begin
            page_idx_q <= nvp_next;
            state_q    <= StLoad;
          end else begin
            blank_q <= BLANK_ALL;
            dp_q    <= '0;
            state_q <= StIdle;
          end
        end
        StLoad: begin
          digits_q    <= page_sel;
          blank_q     <= load_blank;
          dp_q        <= load_dp;
          tick_cnt_q  <= '0;
`ifdef DISPLAY_SCHED_BLINK_EN
          blink_q     <= 1'b0;
          blank_pat_q <= load_blank;
          dp_pat_q    <= load_dp;
`endif
          state_q     <= StShow;
        end
        StShow: begin
`ifdef DISPLAY_SCHED_BLINK_EN
          if (!SAT) begin
            blink_q <= 1'b0;
            blank_q <= blank_pat_q;
            dp_q    <= dp_pat_q;
          end else if (TICK) begin
            blink_q <= ~blink_q;
            blank_q <= blink_q ? blank_pat_q : BLANK_ALL;
            dp_q    <= blink_q ? dp_pat_q : 4'b0000;
          end
`endif
          // NEXT and a terminal TICK together still give a single advance.
          if (NEXT || (TICK && tick_last)) begin
            state_q <= StAdvance;
          end else if (TICK) begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign DIGIT0   = digits_q[3:0];
  assign DIGIT1   = digits_q[7:4];
  assign DIGIT2   = digits_q[11:8];
  assign DIGIT3   = digits_q[15:12];
  assign BLANK    = blank_q;
  assign DP       = dp_q;
  assign PAGE_IDX = page_idx_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed and randomized checks of display_scheduler against a page-level reference model.
module tb_display_scheduler;

  localparam int unsigned Dwell = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick  = 1'b0;
  logic        start = 1'b0;
  logic        nxt   = 1'b0;
  logic        sat   = 1'b0;
  logic [3:0]  valid = 4'b0000;
  logic [15:0] pages [4];
  logic [3:0]  d0, d1, d2, d3, blank, dp;
  logic [1:0]  idx;

  int checks = 0;
  int errors = 0;

  // Reference model: page on display, its snapshot, TICKs seen since load, idle flag.
  int          cur    = 0;
  int          ticks  = 0;
  logic [15:0] snap   = '0;
  bit          idle_m = 1'b1;

  always #5 clk = ~clk;

  display_scheduler #(.DWELL_TICKS(Dwell)) dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .TICK       (tick),
    .START      (start),
    .NEXT       (nxt),
    .SAT        (sat),
    .PAGE_VALID (valid),
    .PAGE0      (pages[0]),
    .PAGE1      (pages[1]),
    .PAGE2      (pages[2]),
    .PAGE3      (pages[3]),
    .DIGIT0     (d0),
    .DIGIT1     (d1),
    .DIGIT2     (d2),
    .DIGIT3     (d3),
    .BLANK      (blank),
    .DP         (dp),
    .PAGE_IDX   (idx)
  );

  function automatic logic [3:0] exp_blank(input logic [15:0] w);
    logic [3:0] b;
    b = '0;
    for (int i = 3; i > 0; i--) begin
      if (w[i*4 +: 4] != 4'd0) break;
      b[i] = 1'b1;
    end
    return b;
  endfunction

  function automatic int next_page(input int c, input logic [3:0] m);
    for (int k = 1; k <= 4; k++) begin
      if (m[(c + k) % 4]) return (c + k) % 4;
    end
    return c;
  endfunction

  function automatic int lowest(input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [15:0] rand_page();
    logic [15:0] w;
    for (int i = 0; i < 4; i++) begin
      w[i*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 9));
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_show(input string tag);
    check({tag, "_idx"}, 32'(idx), 32'(cur));
    check({tag, "_digits"}, 32'({d3, d2, d1, d0}), 32'(snap));
    check({tag, "_blank"}, 32'(blank), 32'(exp_blank(snap)));
    check({tag, "_dp"}, 32'(dp), 32'(4'b0001 << cur));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_blank"}, 32'(blank), 32'hf);
    check({tag, "_dp"}, 32'(dp), 32'h0);
    check({tag, "_idx"}, 32'(idx), 32'(cur));
  endtask

  task automatic load_model(input int p);
    cur    = p;
    snap   = pages[p];
    ticks  = 0;
    idle_m = 1'b0;
  endtask

  // One trigger cycle in SHOW, then either settle the advance or confirm nothing moved.
  task automatic do_event(input bit t, input bit n, input string tag);
    bit adv;
    tick = t;
    nxt  = n;
    step();
    tick = 1'b0;
    nxt  = 1'b0;
    adv  = n || (t && (ticks + 1 == int'(Dwell)));
    if (!adv) begin
      if (t) ticks++;
      check_show({tag, "_hold"});
    end else begin
      step();
      step();
      if (valid == 4'b0000) begin
        idle_m = 1'b1;
        check_idle({tag, "_idle"});
      end else begin
        load_model(next_page(cur, valid));
        check_show({tag, "_adv"});
      end
    end
  endtask

  initial begin
    pages[0] = 16'h0042;
    pages[1] = 16'h1234;
    pages[2] = 16'h0007;
    pages[3] = 16'h0500;

    // Reset state
    step();
    step();
    check("rst_digits", 32'({d3, d2, d1, d0}), 32'h0);
    check("rst_blank", 32'(blank), 32'hf);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_idx", 32'(idx), 32'h0);

    // First page after start
    valid = 4'b1111;
    start = 1'b1;
    rst_n = 1'b1;
    step();
    step();
    load_model(0);
    check("first_digits", 32'({d3, d2, d1, d0}), 32'h0042);
    check("first_blank", 32'(blank), 32'hc);
    check("first_dp", 32'(dp), 32'h1);
    check_show("first");

    // Snapshot holds while page input changes
    pages[0] = 16'h9999;
    step();
    check_show("snapshot");

    // Dwell-driven advance and wrap
    do_event(1'b1, 1'b0, "dwell1");
    do_event(1'b1, 1'b0, "dwell2");
    check("dwell_idx1", 32'(idx), 32'h1);
    for (int i = 0; i < 6; i++) do_event(1'b1, 1'b0, "dwell_loop");
    check("dwell_wrap", 32'(idx), 32'h0);

    // Manual advance with sparse mask, then empty mask
    for (int i = 0; i < 3; i++) do_event(1'b0, 1'b1, "next");
    check("next_idx3", 32'(idx), 32'h3);
    valid = 4'b1010;
    do_event(1'b0, 1'b1, "skip");
    check("skip_idx1", 32'(idx), 32'h1);
    valid = 4'b0000;
    do_event(1'b0, 1'b1, "empty");
    valid = 4'b1111;
    step();
    step();
    load_model(lowest(valid));
    check_show("recover");

    // Simultaneous NEXT and terminal TICK: one advance only
    do_event(1'b1, 1'b0, "dual_pre");
    do_event(1'b1, 1'b1, "dual");
    check("dual_idx", 32'(idx), 32'h1);

    // START drop beats terminal TICK and NEXT
    do_event(1'b1, 1'b0, "stop_pre");
    start = 1'b0;
    tick  = 1'b1;
    nxt   = 1'b1;
    step();
    tick  = 1'b0;
    nxt   = 1'b0;
    check_idle("stop");
    step();
    step();
    check_idle("stop_hold");
    start = 1'b1;
    step();
    step();
    load_model(lowest(valid));
    check_show("restart");

    // Reset pulse while showing page 2
    do_event(1'b0, 1'b1, "to2a");
    do_event(1'b0, 1'b1, "to2b");
    check("on_page2", 32'(idx), 32'h2);
    valid = 4'b1110;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_digits", 32'({d3, d2, d1, d0}), 32'h0);
    check("mid_rst_blank", 32'(blank), 32'hf);
    check("mid_rst_dp", 32'(dp), 32'h0);
    check("mid_rst_idx", 32'(idx), 32'h0);
    step();
    step();
    load_model(1);
    check_show("post_rst");
    valid = 4'b1111;

    // Randomized traffic
    for (int e = 0; e < 150; e++) begin
      if ($urandom_range(0, 9) == 0) valid = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) pages[$urandom_range(0, 3)] = rand_page();
`ifndef DISPLAY_SCHED_BLINK_EN
      sat = 1'($urandom_range(0, 1));
`endif
      if (idle_m) begin
        if (valid != 4'b0000) begin
          step();
          step();
          load_model(lowest(valid));
          check_show("rnd_start");
        end else begin
          step();
        end
      end else begin
        repeat ($urandom_range(0, 2)) step();
        do_event(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), "rnd");
      end
    end
    sat = 1'b0;

    if (idle_m) begin
      valid = 4'b1111;
      step();
      step();
      load_model(lowest(valid));
      check_show("pre_blink");
    end

`ifdef DISPLAY_SCHED_BLINK_EN
    // Saturation blink alternates on TICKs and clears with SAT low
    valid = 4'b1111;
    pages[next_page(cur, valid)] = 16'h0305;
    do_event(1'b0, 1'b1, "blink_load");
    sat  = 1'b1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    ticks++;
    check("blink_on_blank", 32'(blank), 32'hf);
    check("blink_on_dp", 32'(dp), 32'h0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("blink_off_blank", 32'(blank), 32'(exp_blank(snap)));
    check("blink_off_dp", 32'(dp), 32'(4'b0001 << cur));
    step();
    step();
    load_model(next_page(cur, valid));
    check_show("blink_reload");
    tick = 1'b1;
    step();
    tick = 1'b0;
    ticks++;
    check("blink_again", 32'(blank), 32'hf);
    sat = 1'b0;
    step();
    check_show("blink_clear");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
